// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: widths, opcode values and instruction field positions.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {instr, pc} FIFO between the ROM return path and decode.
module fetch_buffer #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_instr,
  input  logic [AW-1:0] i_push_pc,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [1:0]    o_count,
  output logic [DW-1:0] o_head_instr,
  output logic [AW-1:0] o_head_pc
);

  logic [DW-1:0] r_instr [2];
  logic [AW-1:0] r_pc    [2];
  logic          r_rd;
  logic          r_wr;
  logic [1:0]    r_count;

  // Flush only rewinds pointers; stale slots stay hidden behind count==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_instr[r_wr] <= i_push_instr;
        r_pc[r_wr]    <= i_push_pc;
        r_wr          <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_count      = r_count;
  assign o_head_instr = r_instr[r_rd];
  assign o_head_pc    = r_pc[r_rd];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the synchronous ROM, hides its 1-cycle latency and
// hands {ir, ir_pc} to decode with stall, redirect and HALT handling.
module fetch_unit #(
  parameter int              PC_W     = mips_pkg::PC_W,
  parameter int              INSTR_W  = mips_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_en,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               valid,
  output logic               halt
);
  import mips_pkg::*;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_fl_pc;
  logic                r_inflight;

  logic [1:0]          w_count;
  logic [INSTR_W-1:0]  w_head_instr;
  logic [PC_W-1:0]     w_head_pc;
  logic                w_valid;
  logic                w_accept;
  logic                w_issue;
  logic                w_push;
  logic                w_push_halt;
  logic [2:0]          w_occ;

  assign w_valid     = (w_count != 2'd0);
  assign w_accept    = w_valid & ready;
  assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight};
  // A redirect edge drops the word returning from the ROM.
  assign w_push      = r_inflight & ~redirect;
  assign w_push_halt = w_push & (rom_data[OPC_HI:OPC_LO] == OP_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect)         w_state_nxt = ST_RUN;
    else if (w_push_halt) w_state_nxt = ST_HALTED;
  end

  // Issue only if the word will still have a slot when it lands next edge.
  always_comb begin
    w_issue = 1'b0;
    halt    = 1'b0;
    case (r_state)
      ST_RUN:  w_issue = ~redirect & (w_occ <= ({2'b00, w_accept} + 3'd1));
      default: halt    = (w_count == 2'd0);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_fl_pc    <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (redirect)     r_pc <= redirect_pc;
      else if (w_issue) r_pc <= r_pc + 1'b1;
      if (w_issue)      r_fl_pc <= r_pc;
      // The word issued alongside a HALT push is never wanted.
      r_inflight <= w_issue & ~w_push_halt;
    end
  end

  fetch_buffer #(
    .DW (INSTR_W),
    .AW (PC_W)
  ) u_buf (
    .clk          (clk),
    .rst_n        (rst),
    .i_push       (w_push),
    .i_push_instr (rom_data),
    .i_push_pc    (r_fl_pc),
    .i_pop        (w_accept),
    .i_flush      (redirect),
    .o_count      (w_count),
    .o_head_instr (w_head_instr),
    .o_head_pc    (w_head_pc)
  );

  assign rom_addr = r_pc;
  assign rom_en   = w_issue;
  assign ir       = w_head_instr;
  assign ir_pc    = w_head_pc;
  assign valid    = w_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic,
// scored against a program-order model of the delivered instruction stream.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  rom_addr, rom_addr2, ir_pc, ir_pc2, redirect_pc, redirect_pc2;
  logic        rom_en, rom_en2, ready, ready2, redirect, redirect2;
  logic        valid, valid2, halt, halt2;
  logic [31:0] rom_data, rom_data2, ir, ir2;
  logic [31:0] rom [256];

  always @(posedge clk) if (rom_en)  rom_data  <= rom[rom_addr];
  always @(posedge clk) if (rom_en2) rom_data2 <= rom[rom_addr2];

  fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .ready(ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir(ir), .ir_pc(ir_pc), .valid(valid), .halt(halt));

  fetch_unit #(.PC_W(8), .INSTR_W(32), .RESET_PC(8'hFE)) dut_w (
    .clk(clk), .rst(rst), .rom_addr(rom_addr2), .rom_en(rom_en2), .rom_data(rom_data2),
    .ready(ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .ir(ir2), .ir_pc(ir_pc2), .valid(valid2), .halt(halt2));

  int          n_chk, n_err;
  logic [7:0]  exp_pc;
  bit          hlt_acc, p_hold, p_flow;
  int          rd_age;
  logic [7:0]  w2_pc [4];
  logic [31:0] w2_ir [4];
  int          n2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit rom_halt(input logic [7:0] a);
    logic [31:0] w;
    w = rom[a];
    return w[31:26] == OP_HALT;
  endfunction

  task automatic mdl_reset();
    exp_pc  = 8'h00;
    hlt_acc = 1'b0;
    rd_age  = 1;
    p_hold  = 1'b0;
    p_flow  = 1'b0;
  endtask

  // Per-cycle scoreboard, evaluated mid-cycle with inputs stable.
  task automatic mon();
    bit acc, hw;
    if (!rst) begin
      chk("rst_valid", valid, 0);
      chk("rst_halt", halt, 0);
      chk("rst_ir", ir, 0);
      chk("rst_irpc", ir_pc, 0);
      chk("rst_addr", rom_addr, 0);
      mdl_reset();
      return;
    end
    if (valid2 && n2 < 4) begin
      w2_pc[n2] = ir_pc2;
      w2_ir[n2] = ir2;
      chk("wrap_halt", halt2, 0);
      n2++;
    end
    if (rd_age == 1 || rd_age == 2) chk("gap", valid, 0);
    if (rd_age == 3) chk("fill", valid, 1);
    if (p_hold) chk("hold", valid, 1);
    if (p_flow) chk("bubble", valid, 1);
    if (hlt_acc) begin
      chk("halt_hi", halt, 1);
      chk("halt_v", valid, 0);
      chk("halt_en", rom_en, 0);
    end else begin
      chk("halt_lo", halt, 0);
    end
    if (redirect) chk("redir_en", rom_en, 0);
    if (valid) begin
      chk("ir_pc", ir_pc, exp_pc);
      chk("ir", ir, rom[exp_pc]);
    end
    hw  = 1'b0;
    acc = valid & ready;
    if (acc) begin
      hw = rom_halt(exp_pc);
      exp_pc++;
    end
    p_hold = valid & !ready & !redirect;
    p_flow = acc & !hw & !redirect;
    if (redirect) begin
      exp_pc  = redirect_pc;
      hlt_acc = 1'b0;
      rd_age  = 1;
    end else begin
      if (hw) hlt_acc = 1'b1;
      rd_age = (rd_age == 1 || rd_age == 2) ? rd_age + 1 : 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    n_chk = 0; n_err = 0; n2 = 0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[31:26] == OP_HALT) w[26] = 1'b0;
      if (i >= 8'h60 && i <= 8'hFD && $urandom_range(0, 15) == 0) w[31:26] = OP_HALT;
      rom[i] = w;
    end
    rom[0] = 32'h00221820; rom[1] = 32'h8C010004;
    rom[2] = 32'h10000002; rom[3] = 32'hFC000000;

    ready = 0; redirect = 0; redirect_pc = 0;
    ready2 = 1; redirect2 = 0; redirect_pc2 = 0;
    rst = 1;
    mdl_reset();
    #2 rst = 0;
    repeat (3) tick();

    // Program from reset: four words, ending in HALT.
    rst = 1; ready = 1;
    repeat (10) tick();
    chk("s1_halt", halt, 1);
    chk("s1_en", rom_en, 0);

    // Leave HALTED via redirect.
    redirect = 1; redirect_pc = 8'h10;
    tick();
    redirect = 0;
    chk("s2_halt", halt, 0);
    repeat (8) tick();

    // Five-cycle stall mid-stream.
    ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k > 0) begin
        chk("stall_en", rom_en, 0);
        chk("stall_v", valid, 1);
      end
      tick();
    end
    ready = 1;
    repeat (6) tick();

    // Redirect while full and stalled.
    ready = 0;
    repeat (3) tick();
    #1 chk("full_en", rom_en, 0);
    redirect = 1; redirect_pc = 8'h40;
    tick();
    redirect = 0;
    repeat (2) tick();
    ready = 1;
    chk("tgt0_v", valid, 1);
    chk("tgt0", ir_pc, 8'h40);
    tick();
    chk("tgt1", ir_pc, 8'h41);
    repeat (4) tick();

    // Asynchronous reset pulse between edges.
    #1 rst = 0;
    #1;
    chk("ar_valid", valid, 0);
    chk("ar_ir", ir, 0);
    chk("ar_irpc", ir_pc, 0);
    chk("ar_halt", halt, 0);
    chk("ar_addr", rom_addr, 0);
    #1 rst = 1;
    mdl_reset();
    repeat (10) tick();
    chk("s3_halt", halt, 1);

    // Random ready / redirect traffic.
    for (int c = 0; c < 1500; c++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      tick();
    end
    redirect = 0;
    repeat (3) tick();

    // PC wrap on the RESET_PC=0xFE instance.
    chk("wrap_n", n2, 4);
    chk("wrap0", w2_pc[0], 8'hFE);
    chk("wrap1", w2_pc[1], 8'hFF);
    chk("wrap2", w2_pc[2], 8'h00);
    chk("wrap3", w2_pc[3], 8'h01);
    chk("wrap_ir0", w2_ir[0], rom[8'hFE]);
    chk("wrap_ir2", w2_ir[2], rom[8'h00]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
